// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data-cache miss handler.
//
// Contents:
//   - Line geometry: 8 x 64-bit words per line, 6 set bits, 3 word bits,
//     3 byte bits, 52 tag bits.
//   - miss_state_e: miss handler FSM states.
//   - miss_req_t: registered copy of the miss being served.
//   - SZ_B/SZ_H/SZ_W/SZ_D: bus size codes.
//   - line_align/same_line helpers.
package dcache_pkg;

  localparam int LINE_WORDS  = 8;
  localparam int SET_BITS    = 6;
  localparam int WORD_BITS   = 3;
  localparam int BYTE_BITS   = 3;
  localparam int OFFSET_BITS = WORD_BITS + BYTE_BITS;
  localparam int TAG_BITS    = 64 - SET_BITS - OFFSET_BITS;
  localparam int LINE_BITS   = 64 * LINE_WORDS;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;
  localparam logic [2:0] SZ_D = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    WACK,
    DONE
  } miss_state_e;

  // slot: 0 = MEM slot 1, 1 = MEM slot 2
  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [63:0] data;
    logic        slot;
  } miss_req_t;

  function automatic logic [63:0] line_align(input logic [63:0] addr);
    return {addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  function automatic logic same_line(input logic [63:0] a, input logic [63:0] b);
    return a[63:OFFSET_BITS] == b[63:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// dcache_miss_ctrl_if: memory bus between the miss handler and memory.
//
// Signals:
//   bus_req_valid/ready  request handshake (fires on valid & ready)
//   bus_req_addr         request address (line-aligned for reads)
//   bus_req_write        1 = store, 0 = line read
//   bus_req_size         size code, SZ_D for line reads
//   bus_req_data         store data
//   bus_resp_valid       one read beat or the store acknowledge
//   bus_resp_data        read beat data
// Modports: master = miss handler, slave = memory side.
interface dcache_miss_ctrl_if;

  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_req_addr;
  logic        bus_req_write;
  logic [2:0]  bus_req_size;
  logic [63:0] bus_req_data;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;

  modport master (
    output bus_req_valid,
    output bus_req_addr,
    output bus_req_write,
    output bus_req_size,
    output bus_req_data,
    input  bus_req_ready,
    input  bus_resp_valid,
    input  bus_resp_data
  );

  modport slave (
    input  bus_req_valid,
    input  bus_req_addr,
    input  bus_req_write,
    input  bus_req_size,
    input  bus_req_data,
    output bus_req_ready,
    output bus_resp_valid,
    output bus_resp_data
  );

endinterface

// File: rtl/dcache_line_buf.sv
// dcache_line_buf: assembles refill beats into one cache line.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   beat_en       accept beat_data into word cnt this cycle
//   beat_data     64-bit beat
//   last_beat     beat_en on the final word (cnt = LINE_WORDS-1)
//   line_next     line contents including the beat being accepted this
//                 cycle, so the final beat can be registered together
//                 with the rest of the line
module dcache_line_buf
  import dcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 beat_en,
  input  logic [63:0]          beat_data,
  output logic                 last_beat,
  output logic [LINE_BITS-1:0] line_next
);

  logic [WORD_BITS-1:0] cnt;
  logic [LINE_BITS-1:0] line_q;

  // Merge the incoming beat into its word slot.
  always_comb begin
    line_next = line_q;
    if (beat_en) begin
      line_next[{cnt, 6'd0} +: 64] = beat_data;
    end
  end

  assign last_beat = beat_en && (cnt == WORD_BITS'(LINE_WORDS - 1));

  // The counter wraps to 0 after the last beat, ready for the next refill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      line_q <= '0;
    end else if (beat_en) begin
      cnt    <= cnt + 1'b1;
      line_q <= line_next;
    end
  end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: miss handler for the dual-issue data-cache MEM stage.
//
// Load misses become 8-beat line refills; store misses become single
// write-through bus stores (no allocate). Slot 1 has priority over slot 2.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   MEM_miss1/2                   slot miss request, held until served
//   MEM_addr1/2                   miss byte address
//   MEM_Write1/2                  1 = store miss, 0 = load miss
//   MEM_Size1/2, MEM_Data1/2      store size code and data
//   bus                           memory bus (master side)
//   fill_valid                    one-cycle pulse, line ready
//   fill_set, fill_tag, fill_data filled line (word 0 in bits [63:0]),
//                                 held between fills
//   done1/done2                   one-cycle pulse, slot's miss served
//
// Build option: DCACHE_MISS_MERGE_EN - two load misses to the same line
// present together in IDLE share one refill and complete together.
module dcache_miss_ctrl
  import dcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 MEM_miss1,
  input  logic                 MEM_miss2,
  input  logic [63:0]          MEM_addr1,
  input  logic [63:0]          MEM_addr2,
  input  logic                 MEM_Write1,
  input  logic                 MEM_Write2,
  input  logic [2:0]           MEM_Size1,
  input  logic [2:0]           MEM_Size2,
  input  logic [63:0]          MEM_Data1,
  input  logic [63:0]          MEM_Data2,
  dcache_miss_ctrl_if.master   bus,
  output logic                 fill_valid,
  output logic [SET_BITS-1:0]  fill_set,
  output logic [TAG_BITS-1:0]  fill_tag,
  output logic [LINE_BITS-1:0] fill_data,
  output logic                 done1,
  output logic                 done2
);

  miss_state_e          state;
  miss_req_t            req_q;
  miss_req_t            cap;
  logic                 req_valid_q;
  logic                 merged_q;
  logic                 merge_hit;
  logic                 beat_en;
  logic                 last_beat;
  logic [LINE_BITS-1:0] line_next;

  // Bus request fields come straight from the captured request, so they
  // are registered and stable for the whole REQ phase.
  assign bus.bus_req_valid = req_valid_q;
  assign bus.bus_req_addr  = req_q.addr;
  assign bus.bus_req_write = req_q.write;
  assign bus.bus_req_size  = req_q.size;
  assign bus.bus_req_data  = req_q.data;

  // Request that IDLE would capture; slot 1 wins. Reads go out
  // line-aligned as a doubleword-sized line request.
  always_comb begin
    cap = '0;
    if (MEM_miss1) begin
      cap.addr  = MEM_Write1 ? MEM_addr1 : line_align(MEM_addr1);
      cap.write = MEM_Write1;
      cap.size  = MEM_Write1 ? MEM_Size1 : SZ_D;
      cap.data  = MEM_Write1 ? MEM_Data1 : 64'd0;
      cap.slot  = 1'b0;
    end else begin
      cap.addr  = MEM_Write2 ? MEM_addr2 : line_align(MEM_addr2);
      cap.write = MEM_Write2;
      cap.size  = MEM_Write2 ? MEM_Size2 : SZ_D;
      cap.data  = MEM_Write2 ? MEM_Data2 : 64'd0;
      cap.slot  = 1'b1;
    end
  end

`ifdef DCACHE_MISS_MERGE_EN
  assign merge_hit = MEM_miss1 && MEM_miss2 && !MEM_Write1 && !MEM_Write2 &&
                     same_line(MEM_addr1, MEM_addr2);
`else
  assign merge_hit = 1'b0;
`endif

  // Beats are only meaningful in FILL; anything earlier is ignored.
  assign beat_en = (state == FILL) && bus.bus_resp_valid;

  dcache_line_buf u_line_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .beat_en   (beat_en),
    .beat_data (bus.bus_resp_data),
    .last_beat (last_beat),
    .line_next (line_next)
  );

  // Miss FSM. fill_valid/done pulses are set on entry to DONE and cleared
  // on the following edge; the fill_* payload is left holding afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      merged_q    <= 1'b0;
      fill_valid  <= 1'b0;
      fill_set    <= '0;
      fill_tag    <= '0;
      fill_data   <= '0;
      done1       <= 1'b0;
      done2       <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      done1      <= 1'b0;
      done2      <= 1'b0;
      case (state)
        IDLE: begin
          if (MEM_miss1 || MEM_miss2) begin
            req_q       <= cap;
            merged_q    <= merge_hit;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= req_q.write ? WACK : FILL;
          end
        end
        FILL: begin
          if (last_beat) begin
            fill_valid <= 1'b1;
            fill_set   <= req_q.addr[OFFSET_BITS +: SET_BITS];
            fill_tag   <= req_q.addr[63 -: TAG_BITS];
            fill_data  <= line_next;
            done1      <= !req_q.slot || merged_q;
            done2      <= req_q.slot || merged_q;
            state      <= DONE;
          end
        end
        WACK: begin
          if (bus.bus_resp_valid) begin
            done1 <= !req_q.slot;
            done2 <= req_q.slot;
            state <= DONE;
          end
        end
        DONE: begin
          merged_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed self-checking bench for dcache_miss_ctrl.
// Acts as the MEM stage (raises/drops misses) and as the memory bus.
// Expectations follow DCACHE_MISS_MERGE_EN when it is defined.
module tb_dcache_miss_ctrl;
  import dcache_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 MEM_miss1, MEM_miss2;
  logic [63:0]          MEM_addr1, MEM_addr2;
  logic                 MEM_Write1, MEM_Write2;
  logic [2:0]           MEM_Size1, MEM_Size2;
  logic [63:0]          MEM_Data1, MEM_Data2;
  logic                 fill_valid;
  logic [SET_BITS-1:0]  fill_set;
  logic [TAG_BITS-1:0]  fill_tag;
  logic [LINE_BITS-1:0] fill_data;
  logic                 done1, done2;

  dcache_miss_ctrl_if bus ();

  dcache_miss_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MEM_miss1  (MEM_miss1),
    .MEM_miss2  (MEM_miss2),
    .MEM_addr1  (MEM_addr1),
    .MEM_addr2  (MEM_addr2),
    .MEM_Write1 (MEM_Write1),
    .MEM_Write2 (MEM_Write2),
    .MEM_Size1  (MEM_Size1),
    .MEM_Size2  (MEM_Size2),
    .MEM_Data1  (MEM_Data1),
    .MEM_Data2  (MEM_Data2),
    .bus        (bus),
    .fill_valid (fill_valid),
    .fill_set   (fill_set),
    .fill_tag   (fill_tag),
    .fill_data  (fill_data),
    .done1      (done1),
    .done2      (done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation state kept by the monitors below.
  int          edges = 0;
  int          done1_cnt = 0, done2_cnt = 0, fill_cnt = 0;
  int          done1_edge = 0, done2_edge = 0;
  logic [63:0]          req_addr_q[$];
  logic [63:0]          req_data_q[$];
  logic [3:0]           req_ws_q[$];
  logic [LINE_BITS-1:0] snap_data;
  logic [SET_BITS-1:0]  snap_set;
  logic [TAG_BITS-1:0]  snap_tag;

  // Count edges and log every accepted bus request.
  always @(posedge clk) begin
    edges++;
    if (bus.bus_req_valid === 1'b1 && bus.bus_req_ready === 1'b1) begin
      req_addr_q.push_back(bus.bus_req_addr);
      req_data_q.push_back(bus.bus_req_data);
      req_ws_q.push_back({bus.bus_req_write, bus.bus_req_size});
    end
  end

  // Record completion pulses and snapshot the filled line.
  always @(negedge clk) begin
    if (done1 === 1'b1) begin done1_cnt++; done1_edge = edges; end
    if (done2 === 1'b1) begin done2_cnt++; done2_edge = edges; end
    if (fill_valid === 1'b1) begin
      fill_cnt++;
      snap_data = fill_data;
      snap_set  = fill_set;
      snap_tag  = fill_tag;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise a miss on one slot (0 = slot 1, 1 = slot 2).
  task automatic applyStimulus(input bit slot, input logic [63:0] addr, input bit write,
                               input logic [2:0] size, input logic [63:0] data);
    if (!slot) begin
      MEM_addr1 = addr; MEM_Write1 = write; MEM_Size1 = size; MEM_Data1 = data;
      MEM_miss1 = 1'b1;
    end else begin
      MEM_addr2 = addr; MEM_Write2 = write; MEM_Size2 = size; MEM_Data2 = data;
      MEM_miss2 = 1'b1;
    end
  endtask

  // Memory side of one transfer: wait for a request, accept it after
  // ready_delay cycles, then return either `beats` back-to-back beats
  // (base, base+1, ...) or a store ack after ack_delay cycles. A full
  // transfer ends in the done cycle, where the cache drops the misses in drop.
  task automatic serveBus(input int ready_delay, input int ack_delay, input int beats,
                          input logic [63:0] base, input bit is_write, input bit [1:0] drop);
    int waited = 0;
    while (bus.bus_req_valid !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.bus_req_valid !== 1'b1) begin
      checkOutput("req_timeout", 64'(bus.bus_req_valid), 64'd1);
      MEM_miss1 = 1'b0;
      MEM_miss2 = 1'b0;
      return;
    end
    repeat (ready_delay) @(negedge clk);
    bus.bus_req_ready = 1'b1;
    @(negedge clk);
    bus.bus_req_ready = 1'b0;
    if (is_write) begin
      repeat (ack_delay) @(negedge clk);
      bus.bus_resp_valid = 1'b1;
      @(negedge clk);
      bus.bus_resp_valid = 1'b0;
    end else begin
      for (int i = 0; i < beats; i++) begin
        bus.bus_resp_valid = 1'b1;
        bus.bus_resp_data  = base + 64'(i);
        @(negedge clk);
      end
      bus.bus_resp_valid = 1'b0;
      if (beats < LINE_WORDS) return;
    end
    if (drop[0]) MEM_miss1 = 1'b0;
    if (drop[1]) MEM_miss2 = 1'b0;
  endtask

  // Pop the oldest logged request and compare its fields.
  task automatic checkReq(input string tag, input logic [63:0] addr, input bit write,
                          input logic [2:0] size, input logic [63:0] data);
    logic [3:0] ws;
    checkOutput({tag, "_present"}, 64'(req_addr_q.size() != 0), 64'd1);
    if (req_addr_q.size() != 0) begin
      ws = req_ws_q.pop_front();
      checkOutput({tag, "_addr"}, req_addr_q.pop_front(), addr);
      checkOutput({tag, "_write"}, 64'(ws[3]), 64'(write));
      checkOutput({tag, "_size"}, 64'(ws[2:0]), 64'(size));
      checkOutput({tag, "_data"}, req_data_q.pop_front(), data);
    end
  endtask

  initial begin
    int t0, d1, d2, f0;
    reset_n = 1'b0;
    MEM_miss1 = 0; MEM_miss2 = 0; MEM_addr1 = 0; MEM_addr2 = 0;
    MEM_Write1 = 0; MEM_Write2 = 0; MEM_Size1 = 0; MEM_Size2 = 0;
    MEM_Data1 = 0; MEM_Data2 = 0;
    bus.bus_req_ready = 0; bus.bus_resp_valid = 0; bus.bus_resp_data = 0;

    // Reset state
    idle(3);
    checkOutput("rst_req_valid", 64'(bus.bus_req_valid), 64'd0);
    checkOutput("rst_req_addr", bus.bus_req_addr, 64'd0);
    checkOutput("rst_fill_valid", 64'(fill_valid), 64'd0);
    checkOutput("rst_done", 64'({done1, done2}), 64'd0);
    checkOutput("rst_fill_w0", fill_data[63:0], 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Slot 1 load miss, minimum latency refill
    $display("[TB] slot 1 load miss 0x1048");
    t0 = edges;
    applyStimulus(1'b0, 64'h1048, 1'b0, SZ_D, 64'd0);
    serveBus(0, 0, 8, 64'h100, 1'b0, 2'b01);
    idle(3);
    checkReq("t1_req", 64'h1040, 1'b0, SZ_D, 64'd0);
    checkOutput("t1_latency", 64'(done1_edge - t0), 64'd10);
    checkOutput("t1_fill_cnt", 64'(fill_cnt), 64'd1);
    checkOutput("t1_done_cnt", 64'({done1_cnt[7:0], done2_cnt[7:0]}), 64'h0100);
    checkOutput("t1_set", 64'(snap_set), 64'd1);
    checkOutput("t1_tag", 64'(snap_tag), 64'd1);
    checkOutput("t1_w0", snap_data[63:0], 64'h100);
    checkOutput("t1_w7", snap_data[511:448], 64'h107);
    checkOutput("t1_fill_pulse", 64'(fill_valid), 64'd0);

    // Slot 2 store miss with bus wait states
    $display("[TB] slot 2 store miss 0x2000");
    applyStimulus(1'b1, 64'h2000, 1'b1, SZ_D, 64'hDEAD);
    serveBus(3, 2, 0, 64'd0, 1'b1, 2'b10);
    idle(3);
    checkReq("t2_req", 64'h2000, 1'b1, SZ_D, 64'hDEAD);
    checkOutput("t2_done_cnt", 64'({done1_cnt[7:0], done2_cnt[7:0]}), 64'h0101);
    checkOutput("t2_no_fill", 64'(fill_cnt), 64'd1);
    checkOutput("t2_fill_hold", fill_data[63:0], 64'h100);

    // Both slots miss, different lines
    $display("[TB] dual miss 0x1000 / 0x3000");
    applyStimulus(1'b0, 64'h1000, 1'b0, SZ_D, 64'd0);
    applyStimulus(1'b1, 64'h3000, 1'b0, SZ_D, 64'd0);
    serveBus(0, 0, 8, 64'h200, 1'b0, 2'b01);
    serveBus(0, 0, 8, 64'h300, 1'b0, 2'b10);
    idle(3);
    checkReq("t3_req_a", 64'h1000, 1'b0, SZ_D, 64'd0);
    checkReq("t3_req_b", 64'h3000, 1'b0, SZ_D, 64'd0);
    checkOutput("t3_order", 64'(done2_edge > done1_edge), 64'd1);
    checkOutput("t3_tag", 64'(snap_tag), 64'd3);
    checkOutput("t3_set", 64'(snap_set), 64'd0);
    checkOutput("t3_w0", snap_data[63:0], 64'h300);

    // Both slots load the same line
    $display("[TB] same-line loads 0x1008 / 0x1030");
    d1 = done1_cnt; d2 = done2_cnt; f0 = fill_cnt;
    req_addr_q.delete(); req_data_q.delete(); req_ws_q.delete();
    applyStimulus(1'b0, 64'h1008, 1'b0, SZ_D, 64'd0);
    applyStimulus(1'b1, 64'h1030, 1'b0, SZ_D, 64'd0);
`ifdef DCACHE_MISS_MERGE_EN
    serveBus(0, 0, 8, 64'h400, 1'b0, 2'b11);
    idle(3);
    checkOutput("t4_req_cnt", 64'(req_addr_q.size()), 64'd1);
    checkOutput("t4_same_edge", 64'(done1_edge == done2_edge), 64'd1);
    checkOutput("t4_fills", 64'(fill_cnt - f0), 64'd1);
    checkOutput("t4_w0", snap_data[63:0], 64'h400);
`else
    serveBus(0, 0, 8, 64'h400, 1'b0, 2'b01);
    serveBus(0, 0, 8, 64'h500, 1'b0, 2'b10);
    idle(3);
    checkOutput("t4_req_cnt", 64'(req_addr_q.size()), 64'd2);
    checkReq("t4_req_a", 64'h1000, 1'b0, SZ_D, 64'd0);
    checkReq("t4_req_b", 64'h1000, 1'b0, SZ_D, 64'd0);
    checkOutput("t4_order", 64'(done2_edge > done1_edge), 64'd1);
    checkOutput("t4_fills", 64'(fill_cnt - f0), 64'd2);
    checkOutput("t4_w0", snap_data[63:0], 64'h500);
`endif
    checkOutput("t4_done1", 64'(done1_cnt - d1), 64'd1);
    checkOutput("t4_done2", 64'(done2_cnt - d2), 64'd1);

    // Reset in the middle of a refill
    $display("[TB] reset after 4 beats");
    req_addr_q.delete(); req_data_q.delete(); req_ws_q.delete();
    applyStimulus(1'b0, 64'h5000, 1'b0, SZ_D, 64'd0);
    serveBus(0, 0, 4, 64'h700, 1'b0, 2'b00);
    reset_n = 1'b0;
    MEM_miss1 = 1'b0;
    #1;
    checkOutput("t5_req_valid", 64'(bus.bus_req_valid), 64'd0);
    checkOutput("t5_req_addr", bus.bus_req_addr, 64'd0);
    checkOutput("t5_fill_w0", fill_data[63:0], 64'd0);
    checkOutput("t5_pulses", 64'({fill_valid, done1, done2}), 64'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    applyStimulus(1'b0, 64'h6000, 1'b0, SZ_D, 64'd0);
    serveBus(0, 0, 8, 64'h600, 1'b0, 2'b01);
    idle(3);
    checkOutput("t5_w0", snap_data[63:0], 64'h600);
    checkOutput("t5_w7", snap_data[511:448], 64'h607);
    checkOutput("t5_tag", 64'(snap_tag), 64'd6);

    // Stalled request while the slot address keeps changing; a stray
    // response in REQ must not count as a beat
    $display("[TB] stalled request, toggling MEM_addr1");
    applyStimulus(1'b0, 64'h7088, 1'b0, SZ_D, 64'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      MEM_addr1 = 64'hF000 + 64'(i) * 64'h1000;
      bus.bus_resp_valid = (i == 2);
      bus.bus_resp_data  = 64'hBAD;
      @(negedge clk);
      checkOutput("t6_addr_stable", bus.bus_req_addr, 64'h7080);
    end
    bus.bus_resp_valid = 1'b0;
    serveBus(0, 0, 8, 64'h800, 1'b0, 2'b01);
    idle(3);
    checkOutput("t6_w0", snap_data[63:0], 64'h800);
    checkOutput("t6_w7", snap_data[511:448], 64'h807);
    checkOutput("t6_set", 64'(snap_set), 64'd2);
    checkOutput("t6_tag", 64'(snap_tag), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed 0x0 expected 0x1");
    $fatal(1, "[TB] timeout");
  end

endmodule
